// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the load/store unit.
package mem_access_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_RD_WAIT,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = |off[1:0];
            SZ_D:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mem_access_lane_align.sv
// Byte-lane datapath: load extract/extend and store positioning/merge.
module lane_align
    import mem_access_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic              zext_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] ld_data_o,
    output logic [NB-1:0]     st_be_o,
    output logic [DATA_W-1:0] st_data_o,
    output logic [DATA_W-1:0] merged_o
);
    logic [DATA_W-1:0]        shifted, up, zx, sx, wmask, lane_mask;
    logic signed [DATA_W-1:0] up_s;
    logic [NB-1:0]            size_nb;
    logic [6:0]               lsh;

    // Park the lane at the top, then shift back down to get either extension.
    always_comb begin
        case (size_i)
            SZ_B:    lsh = 7'(DATA_W - 8);
            SZ_H:    lsh = 7'(DATA_W - 16);
            SZ_W:    lsh = 7'(DATA_W - 32);
            default: lsh = 7'd0;
        endcase
    end

    assign shifted   = rdata_i >> {off_i, 3'b000};
    assign up        = shifted << lsh;
    assign up_s      = up;
    assign sx        = up_s >>> lsh;
    assign zx        = up >> lsh;
    assign ld_data_o = zext_i ? zx : sx;

    assign size_nb = NB'(size_mask(size_i));
    assign st_be_o = size_nb << off_i;

    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign wmask[i*8 +: 8]     = {8{size_nb[i]}};
        assign lane_mask[i*8 +: 8] = {8{st_be_o[i]}};
    end

    assign st_data_o = (wdata_i & wmask) << {off_i, 3'b000};
    assign merged_o  = (rdata_i & ~lane_mask) | st_data_o;
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request handshake, fault screening and memory port sequencing.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int ADDR_W      = 32,
    parameter  bit USE_BYTE_EN = 1'b1,
    localparam int NB          = DATA_W / 8,
    localparam int OFF_W       = $clog2(NB)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_fault_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [NB-1:0]     mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam logic [1:0] FULL_SZ = (DATA_W == 64) ? SZ_D : SZ_W;

    state_e            state_q, state_d;
    logic              we_q, zext_q, fault_q;
    logic [1:0]        size_q, req_size;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, merged_q;
    logic [DATA_W-1:0] ld_data, st_data, merged;
    logic [NB-1:0]     st_be;
    logic              accept, illegal, fault_acc, direct_wr;

    assign req_size  = req_funct3_i[1:0];
    assign accept    = req_valid_i && req_ready_o;
    assign illegal   = (req_size == SZ_D && DATA_W == 32)
                    || (!req_we_i && req_funct3_i == 3'b111)
                    || (req_we_i && req_funct3_i[2]);
    assign fault_acc = illegal || misaligned(req_size, 3'(req_addr_i[OFF_W-1:0]));
    // Sub-word stores without byte enables must read the word first.
    assign direct_wr = we_q && (USE_BYTE_EN || size_q == FULL_SZ);

    lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i   (size_q),
        .zext_i   (zext_q),
        .off_i    (addr_q[OFF_W-1:0]),
        .rdata_i  (mem_rdata_i),
        .wdata_i  (wdata_q),
        .ld_data_o(ld_data),
        .st_be_o  (st_be),
        .st_data_o(st_data),
        .merged_o (merged)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_fault_o = fault_q;
    assign mem_req_o    = (state_q == ST_MEM_REQ) || (state_q == ST_RMW_WR);
    assign mem_addr_o   = addr_q & ~ADDR_W'(NB - 1);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (state_q == ST_MEM_REQ && direct_wr) begin
            mem_we_o    = 1'b1;
            mem_be_o    = st_be;
            mem_wdata_o = st_data;
        end else if (state_q == ST_RMW_WR) begin
            mem_we_o    = 1'b1;
            mem_be_o    = '1;
            mem_wdata_o = merged_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_valid_i)  state_d = fault_acc ? ST_RESP : ST_MEM_REQ;
            ST_MEM_REQ: if (mem_gnt_i)    state_d = direct_wr ? ST_RESP : ST_RD_WAIT;
            ST_RD_WAIT: if (mem_rvalid_i) state_d = we_q ? ST_RMW_WR : ST_RESP;
            ST_RMW_WR:  if (mem_gnt_i)    state_d = ST_RESP;
            ST_RESP:    if (resp_ready_i) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            zext_q   <= 1'b0;
            fault_q  <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we_i;
                zext_q  <= req_funct3_i[2];
                size_q  <= req_size;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                fault_q <= fault_acc;
            end
            if (state_q == ST_RD_WAIT && mem_rvalid_i) begin
                if (we_q) merged_q <= merged;
                else      rdata_q  <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: three unit configurations (32b byte-enable, 32b RMW, 64b).
module tb_mem_access_unit;
    typedef struct { logic we; logic [31:0] addr; logic [7:0] be; logic [63:0] wdata; } mtx_t;
    typedef struct { logic [63:0] rdata; logic fault; } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        req_valid [3];
    logic        req_we    [3];
    logic [2:0]  req_f3    [3];
    logic [31:0] req_addr  [3];
    logic [63:0] req_wdata [3];
    logic        resp_ready[3] = '{0, 0, 0};
    logic        mem_gnt   [3] = '{0, 0, 0};
    logic        mem_rvalid[3] = '{0, 0, 0};
    logic [63:0] mem_rdata [3] = '{0, 0, 0};

    wire         req_ready [3];
    wire         resp_valid[3];
    wire         resp_fault[3];
    wire         mem_req   [3];
    wire         mem_we    [3];
    wire  [31:0] mem_addr  [3];
    wire  [63:0] o_rdata   [3];
    wire  [63:0] o_wdata   [3];
    wire  [7:0]  o_be      [3];
    wire  [31:0] rd0, rd1, wd0, wd1;
    wire  [3:0]  be0, be1;
    assign o_rdata[0] = {32'h0, rd0};
    assign o_rdata[1] = {32'h0, rd1};
    assign o_wdata[0] = {32'h0, wd0};
    assign o_wdata[1] = {32'h0, wd1};
    assign o_be[0]    = {4'h0, be0};
    assign o_be[1]    = {4'h0, be1};

    int          nvec = 0, nerr = 0;
    mtx_t        mq [3][$];
    rsp_t        rq [3][$];
    int          gnt_dly[3] = '{0, 0, 0};
    int          rv_dly [3] = '{1, 1, 1};
    int          rdy_dly[3] = '{0, 0, 0};
    logic [63:0] mem_word[3] = '{0, 0, 0};
    int          req_cycles[3] = '{0, 0, 0};
    int          resp_cnt[3] = '{0, 0, 0};

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .USE_BYTE_EN(1'b1)) u_be (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0][31:0]), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_rdata_o(rd0), .resp_fault_o(resp_fault[0]), .mem_req_o(mem_req[0]), .mem_gnt_i(mem_gnt[0]),
        .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_be_o(be0), .mem_wdata_o(wd0),
        .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0][31:0]));

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .USE_BYTE_EN(1'b0)) u_rmw (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1][31:0]), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_rdata_o(rd1), .resp_fault_o(resp_fault[1]), .mem_req_o(mem_req[1]), .mem_gnt_i(mem_gnt[1]),
        .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_be_o(be1), .mem_wdata_o(wd1),
        .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1][31:0]));

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .USE_BYTE_EN(1'b1)) u_64 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_we_i(req_we[2]), .req_funct3_i(req_f3[2]), .req_addr_i(req_addr[2]),
        .req_wdata_i(req_wdata[2]), .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
        .resp_rdata_o(o_rdata[2]), .resp_fault_o(resp_fault[2]), .mem_req_o(mem_req[2]), .mem_gnt_i(mem_gnt[2]),
        .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]), .mem_be_o(o_be[2]), .mem_wdata_o(o_wdata[2]),
        .mem_rvalid_i(mem_rvalid[2]), .mem_rdata_i(mem_rdata[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        nvec++;
        nerr++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory model and response monitor, one per unit; everything sampled on negedge.
    for (genvar k = 0; k < 3; k++) begin : g_port
        int          gcnt = 0, rcnt = 0, wcnt = 0;
        bit          rd_pend = 0, hold = 0, rhold = 0;
        logic        h_we, h_flt;
        logic [31:0] h_addr;
        logic [7:0]  h_be;
        logic [63:0] h_wd, h_rd;

        always @(negedge clk) begin
            mtx_t m;
            rsp_t r;
            mem_gnt[k]    = 1'b0;
            mem_rvalid[k] = 1'b0;
            resp_ready[k] = 1'b0;
            if (mem_req[k]) req_cycles[k]++;
            if (hold) begin
                check($sformatf("u%0d mem_req held", k), {mem_req[k], mem_we[k], mem_addr[k], o_be[k]},
                      {1'b1, h_we, h_addr, h_be});
                check($sformatf("u%0d mem_wdata held", k), o_wdata[k], h_wd);
            end
            hold = 0;
            if (rd_pend) begin
                rcnt--;
                if (rcnt <= 0) begin
                    rd_pend = 0;
                    mem_rvalid[k] = 1'b1;
                end
            end
            mem_rdata[k] = mem_rvalid[k] ? mem_word[k] : ~mem_word[k];
            if (mem_req[k]) begin
                if (gcnt >= gnt_dly[k]) begin
                    gcnt = 0;
                    mem_gnt[k] = 1'b1;
                    if (mq[k].size() == 0) begin
                        fail($sformatf("u%0d mem_req", k), $sformatf("got request addr %h, expected none", mem_addr[k]));
                    end else begin
                        m = mq[k].pop_front();
                        check($sformatf("u%0d mem_we", k), 64'(mem_we[k]), 64'(m.we));
                        check($sformatf("u%0d mem_addr", k), 64'(mem_addr[k]), 64'(m.addr));
                        if (m.we) begin
                            check($sformatf("u%0d mem_be", k), 64'(o_be[k]), 64'(m.be));
                            check($sformatf("u%0d mem_wdata", k), o_wdata[k], m.wdata);
                        end else begin
                            rd_pend = 1;
                            rcnt = rv_dly[k];
                        end
                    end
                end else begin
                    gcnt++;
                    hold = 1;
                    h_we = mem_we[k]; h_addr = mem_addr[k]; h_be = o_be[k]; h_wd = o_wdata[k];
                end
            end
            if (rhold) begin
                check($sformatf("u%0d resp held", k), {resp_valid[k], resp_fault[k]}, {1'b1, h_flt});
                check($sformatf("u%0d resp_rdata held", k), o_rdata[k], h_rd);
            end
            rhold = 0;
            if (resp_valid[k]) begin
                if (wcnt >= rdy_dly[k]) begin
                    wcnt = 0;
                    resp_ready[k] = 1'b1;
                    resp_cnt[k]++;
                    if (rq[k].size() == 0) begin
                        fail($sformatf("u%0d resp", k), $sformatf("got resp_valid rdata %h, expected none", o_rdata[k]));
                    end else begin
                        r = rq[k].pop_front();
                        check($sformatf("u%0d resp_rdata", k), o_rdata[k], r.rdata);
                        check($sformatf("u%0d resp_fault", k), 64'(resp_fault[k]), 64'(r.fault));
                    end
                end else begin
                    wcnt++;
                    rhold = 1;
                    h_rd = o_rdata[k]; h_flt = resp_fault[k];
                end
            end
        end
    end

    task automatic exp_mem(input int k, input logic we, input logic [31:0] a, input logic [7:0] be,
                           input logic [63:0] wd);
        mtx_t m;
        m.we = we; m.addr = a; m.be = be; m.wdata = wd;
        mq[k].push_back(m);
    endtask

    task automatic issue(input int k, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input bit has_rsp, input logic [63:0] erd, input logic eflt);
        rsp_t r;
        int t;
        if (has_rsp) begin
            r.rdata = erd; r.fault = eflt;
            rq[k].push_back(r);
        end
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_f3[k] = f3; req_addr[k] = a; req_wdata[k] = wd;
        t = 0;
        while (!req_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[k]) fail($sformatf("u%0d accept", k), "got req_ready=0 for 200 cycles, expected 1");
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_wdata[k] = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        while ((rq[k].size() != 0 || mq[k].size() != 0 || !req_ready[k]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("u%0d drained", k), 64'(rq[k].size() + mq[k].size()), 64'd0);
        check($sformatf("u%0d idle ready", k), 64'(req_ready[k]), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int c, n;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_f3[k] = 3'b0; req_addr[k] = '0; req_wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d reset ctl", k), {req_ready[k], resp_valid[k], resp_fault[k], mem_req[k], mem_we[k]},
                  64'b10000);
            check($sformatf("u%0d reset rdata", k), o_rdata[k], 64'd0);
            check($sformatf("u%0d reset addr/be", k), {mem_addr[k], o_be[k]}, 64'd0);
            check($sformatf("u%0d reset wdata", k), o_wdata[k], 64'd0);
        end
        rst = 1'b0;

        // 32-bit, byte enables
        mem_word[0] = 64'h80FF_1234;
        exp_mem(0, 0, 32'h1000, 0, 0); issue(0, 0, 3'b100, 32'h1003, 0, 1, 64'h80, 0);          wait_done(0);
        exp_mem(0, 0, 32'h1000, 0, 0); issue(0, 0, 3'b000, 32'h1003, 0, 1, 64'hFFFF_FF80, 0);   wait_done(0);
        mem_word[0] = 64'h8001_0000;
        exp_mem(0, 0, 32'h1000, 0, 0); issue(0, 0, 3'b001, 32'h1002, 0, 1, 64'hFFFF_8001, 0);   wait_done(0);
        exp_mem(0, 0, 32'h1000, 0, 0); issue(0, 0, 3'b101, 32'h1002, 0, 1, 64'h8001, 0);        wait_done(0);
        c = req_cycles[0];
        issue(0, 0, 3'b001, 32'h1001, 0, 1, 0, 1); wait_done(0);
        check("LH misaligned mem_req cycles", 64'(req_cycles[0] - c), 64'd0);
        exp_mem(0, 1, 32'h2000, 8'h02, 64'h0000_AB00);
        issue(0, 1, 3'b000, 32'h2001, 64'h1234_56AB, 1, 0, 0);                                   wait_done(0);
        exp_mem(0, 1, 32'h0040, 8'h0C, 64'hBEEF_0000);
        issue(0, 1, 3'b001, 32'h0042, 64'h1234_BEEF, 1, 0, 0);                                   wait_done(0);
        exp_mem(0, 1, 32'h0040, 8'h0F, 64'h89AB_CDEF);
        issue(0, 1, 3'b010, 32'h0040, 64'h89AB_CDEF, 1, 0, 0);                                   wait_done(0);
        c = req_cycles[0];
        issue(0, 0, 3'b111, 32'h0000, 0, 1, 0, 1); wait_done(0);
        issue(0, 1, 3'b100, 32'h0000, 0, 1, 0, 1); wait_done(0);
        issue(0, 0, 3'b011, 32'h0008, 0, 1, 0, 1); wait_done(0);
        issue(0, 0, 3'b010, 32'h1002, 0, 1, 0, 1); wait_done(0);
        check("illegal/misaligned mem_req cycles", 64'(req_cycles[0] - c), 64'd0);

        // slow grant, slow read data, slow consumer
        gnt_dly[0] = 5; rv_dly[0] = 3; rdy_dly[0] = 2; mem_word[0] = 64'hCAFE_F00D;
        n = resp_cnt[0];
        exp_mem(0, 0, 32'h3000, 0, 0); issue(0, 0, 3'b010, 32'h3000, 0, 1, 64'hCAFE_F00D, 0);   wait_done(0);
        check("slow LW resp pulses", 64'(resp_cnt[0] - n), 64'd1);
        gnt_dly[0] = 0; rdy_dly[0] = 0;

        // reset while waiting for read data; the late rvalid must be dropped
        rv_dly[0] = 6;
        exp_mem(0, 0, 32'h5000, 0, 0); issue(0, 0, 3'b010, 32'h5000, 0, 0, 0, 0);
        c = 0;
        while (mq[0].size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort ready/valid", {req_ready[0], resp_valid[0]}, 64'b10);
        rv_dly[0] = 1; mem_word[0] = 64'h1357_9BDF;
        exp_mem(0, 0, 32'h6000, 0, 0); issue(0, 0, 3'b010, 32'h6000, 0, 1, 64'h1357_9BDF, 0);   wait_done(0);

        // 32-bit, read-modify-write
        mem_word[1] = 64'h1122_3344;
        exp_mem(1, 0, 32'h2000, 0, 0); exp_mem(1, 1, 32'h2000, 8'h0F, 64'hBEEF_3344);
        issue(1, 1, 3'b001, 32'h2002, 64'hBEEF, 1, 0, 0);                                        wait_done(1);
        exp_mem(1, 0, 32'h2000, 0, 0); exp_mem(1, 1, 32'h2000, 8'h0F, 64'h5A22_3344);
        issue(1, 1, 3'b000, 32'h2003, 64'h5A, 1, 0, 0);                                          wait_done(1);
        exp_mem(1, 1, 32'h2004, 8'h0F, 64'h5566_7788);
        issue(1, 1, 3'b010, 32'h2004, 64'h5566_7788, 1, 0, 0);                                   wait_done(1);
        exp_mem(1, 0, 32'h2000, 0, 0); issue(1, 0, 3'b000, 32'h2001, 0, 1, 64'h33, 0);          wait_done(1);

        // 64-bit
        mem_word[2] = 64'h0123_4567_89AB_CDEF;
        exp_mem(2, 0, 32'h8, 0, 0); issue(2, 0, 3'b011, 32'h8, 0, 1, 64'h0123_4567_89AB_CDEF, 0); wait_done(2);
        mem_word[2] = 64'h8000_0000_0000_0000;
        exp_mem(2, 0, 32'h0, 0, 0); issue(2, 0, 3'b010, 32'h4, 0, 1, 64'hFFFF_FFFF_8000_0000, 0); wait_done(2);
        exp_mem(2, 0, 32'h0, 0, 0); issue(2, 0, 3'b110, 32'h4, 0, 1, 64'h0000_0000_8000_0000, 0); wait_done(2);
        exp_mem(2, 0, 32'h0, 0, 0); issue(2, 0, 3'b000, 32'h7, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0); wait_done(2);
        exp_mem(2, 1, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF);
        issue(2, 1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 1, 0, 0);                           wait_done(2);
        exp_mem(2, 1, 32'h10, 8'hC0, 64'hBEEF_0000_0000_0000);
        issue(2, 1, 3'b001, 32'h16, 64'h1111_2222_3333_BEEF, 1, 0, 0);                           wait_done(2);
        exp_mem(2, 1, 32'h0, 8'hF0, 64'hCAFE_F00D_0000_0000);
        issue(2, 1, 3'b010, 32'h4, 64'hCAFE_F00D, 1, 0, 0);                                      wait_done(2);
        issue(2, 0, 3'b011, 32'h4, 0, 1, 0, 1);                                                  wait_done(2);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit between the RV32I execute stage and the data memory port. Generalises the existing byte/half/word extract-and-merge path.
- Adds a valid/ready request handshake, a grant-based memory port with variable read latency, and misalignment/illegal-size faults.
- Adds selectable byte-enable or read-modify-write store mode, and 64-bit data support.
- Single outstanding transaction.

Parameters:
- DATA_W, 32: memory/register data width; legal values 32 or 64.
- ADDR_W, 32: byte address width.
- USE_BYTE_EN, 1: 1 = stores use mem_be lane masks; 0 = sub-word stores do read-modify-write with mem_be all ones.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] 1 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, rs2.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal access.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned address, low log2(DATA_W/8) bits zero.
- mem_be  out  DATA_W/8  byte-lane write enables.
- mem_wdata  out  DATA_W  lane-positioned write data.
- mem_rvalid  in  1  read data valid, any number of cycles ≥1 after grant.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. Internal request registers cleared.
- States: IDLE, MEM_REQ, RD_WAIT, RMW_WR, RESP.
- req_ready=1 only in IDLE. Request fires on req_valid&&req_ready, and all request fields are registered at that edge.
- Fault check at accept:
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Illegal: size D when DATA_W=32; load with funct3=3'b111; store with funct3[2]=1.
  - On fault: go to RESP with resp_fault=1, resp_rdata=0. No memory traffic is generated.
- Otherwise go to MEM_REQ:
  - mem_req=1. mem_we = store && (USE_BYTE_EN || size==full width).
  - Signals are held stable until mem_gnt. The cycle after grant deasserts mem_req.
  - Write granted → RESP.
  - Read granted → RD_WAIT.
- RD_WAIT ignores mem_gnt and waits for mem_rvalid.
  - Load: extract lane at the byte offset, sign-extend when funct3[2]=0, zero-extend when 1. Register into resp_rdata and go to RESP.
  - RMW store: merge rs2 lane into mem_rdata, go to RMW_WR.
- RMW_WR: mem_req=1, mem_we=1, mem_be all ones, mem_wdata = merged word; on mem_gnt → RESP.
- Write lane rules: mem_wdata = rs2 low bytes shifted to offset*8, other lanes 0. mem_be = size mask << offset (B: 1 bit, H: 2, W: 4, D: 8).
- RESP: resp_valid=1, data held stable until resp_ready, then → IDLE.
  - Minimum load latency with 1-cycle memory: accept (cycle 0), req/grant (1), rvalid (2), resp_valid (3).
  - Next request accepted the cycle after the response handshake.
- Store responses: resp_valid with resp_rdata=0, resp_fault=0.
- mem_rvalid outside RD_WAIT is ignored.
- Rst in any state: return to IDLE the next edge and drop mem_req/resp_valid. A late mem_rvalid from an aborted read is ignored.
- Address offset uses req_addr[log2(DATA_W/8)-1:0]. Upper address bits pass unchanged, with no wrap logic.

Decomposition:
- Package mem_access_pkg:
  - Size encodings SZ_B/H/W/D.
  - State enum.
  - Functions for the size-to-byte-mask and alignment check.
- Sub-module lane_align: combinational extract/extend for loads and shift/merge for stores, parametrised by DATA_W. FSM and handshakes stay in the top.

Test Plan:
- LBU, addr 0x1003, mem_rdata 0x80FF_1234 → resp_rdata 0x0000_0080. LB, same → 0xFFFF_FF80.
- LH, addr 0x1002, mem_rdata 0x8001_0000 → 0xFFFF_8001. LH, addr 0x1001 → resp_fault=1, no mem_req ever asserted.
- SB, USE_BYTE_EN=1, addr 0x2001, rs2 0xAB → mem_be=0010, mem_wdata=0x0000_AB00, mem_addr=0x2000.
- SH, USE_BYTE_EN=0, addr 0x2002, rs2 0xBEEF, mem_rdata 0x1122_3344 → read then write of 0xBEEF_3344 with mem_be=1111.
- mem_gnt held low 5 cycles and mem_rvalid 3 cycles after grant, resp_ready low 2 cycles → mem_req stable throughout, resp_valid/resp_rdata stable until the handshake, single resp_valid pulse per request.
- Rst asserted in RD_WAIT, then mem_rvalid arrives → no resp_valid, req_ready=1. DATA_W=64: LD, addr 0x8 → full word; LW, addr 0x4, mem_rdata 0x8000_0000_0000_0000 → 0xFFFF_FFFF_8000_0000.
